// File: rtl/serial_bit_feeder_if.sv
// Word-in / bit-out bundle of serial_bit_feeder. valid/ready: a word moves on a
// rising edge where din_valid and din_ready are both high; din must be stable while din_valid is high.
interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  modport master (
    output din, din_valid,
    input  din_ready, x, x_valid, busy, done
  );

  modport slave (
    input  din, din_valid,
    output din_ready, x, x_valid, busy, done
  );
endinterface

// File: rtl/serial_bit_feeder.sv
// Serializes parallel words onto the sequence FSM input x, one bit per ck cycle.
// Optional even-parity trailer bit: define SERIAL_BIT_FEEDER_PARITY_EN.
module serial_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 1,
  parameter int GAP       = 0
) (
  input  logic                 ck,
  input  logic                 reset,
  serial_bit_feeder_if.slave   bus,
  output logic [1:0]           fsm_state
);

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FLEN = WIDTH + PAR;
  localparam logic [5:0] LAST     = 6'(FLEN - 1);
  localparam logic [3:0] GAP_LAST = 4'((GAP > 0) ? GAP - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t            state, state_n;
  logic [FLEN-1:0]   sr, sr_n;
  logic [FLEN-1:0]   frame;
  logic [5:0]        bit_cnt, bit_cnt_n;
  logic [3:0]        gap_cnt, gap_cnt_n;
  logic              x_q, x_n;
  logic              xv_q, xv_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              ready_q, ready_n;

  // Frame bits reordered so frame[0] always goes out first.
  always_comb begin
    frame = '0;
    for (int k = 0; k < WIDTH; k++) begin
      frame[k] = (LSB_FIRST != 0) ? bus.din[k] : bus.din[WIDTH-1-k];
    end
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    frame[FLEN-1] = ^bus.din;
`endif
  end

  // Output registers hold next-cycle values, so every output is a flop.
  always_comb begin
    state_n   = state;
    sr_n      = sr;
    bit_cnt_n = bit_cnt;
    gap_cnt_n = gap_cnt;
    x_n       = 1'b0;
    xv_n      = 1'b0;
    busy_n    = 1'b0;
    done_n    = 1'b0;
    ready_n   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.din_valid) begin
          state_n   = ST_SHIFT;
          sr_n      = frame >> 1;
          bit_cnt_n = '0;
          x_n       = frame[0];
          xv_n      = 1'b1;
          busy_n    = 1'b1;
          done_n    = (LAST == 6'd0);
        end else begin
          ready_n = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (bit_cnt == LAST) begin
          if (GAP > 0) begin
            state_n   = ST_GAP;
            gap_cnt_n = '0;
            busy_n    = 1'b1;
          end else begin
            state_n = ST_IDLE;
            ready_n = 1'b1;
          end
        end else begin
          sr_n      = sr >> 1;
          bit_cnt_n = bit_cnt + 6'd1;
          x_n       = sr[0];
          xv_n      = 1'b1;
          busy_n    = 1'b1;
          done_n    = ((bit_cnt + 6'd1) == LAST);
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_n = ST_IDLE;
          ready_n = 1'b1;
        end else begin
          gap_cnt_n = gap_cnt + 4'd1;
          busy_n    = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        ready_n = 1'b1;
      end
    endcase
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      state   <= ST_IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      bit_cnt <= bit_cnt_n;
      gap_cnt <= gap_cnt_n;
      x_q     <= x_n;
      xv_q    <= xv_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      ready_q <= ready_n;
    end
  end

  assign bus.x         = x_q;
  assign bus.x_valid   = xv_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.din_ready = ready_q;
  assign fsm_state     = state;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Bench for serial_bit_feeder: two instances (LSB-first/no gap, MSB-first/gap 3)
// checked every cycle against a frame-level queue model.
module tb_serial_bit_feeder;

  localparam int W = 8;
  localparam int LSB_A = 1;
  localparam int GAP_A = 0;
  localparam int LSB_B = 0;
  localparam int GAP_B = 3;
  // {din_ready, busy, done, x_valid, x}
  localparam logic [4:0] IDLE_V = 5'b10000;

  logic ck = 1'b0;
  logic reset = 1'b0;
  logic [1:0] st_a, st_b;

  serial_bit_feeder_if #(.WIDTH(W)) bus_a ();
  serial_bit_feeder_if #(.WIDTH(W)) bus_b ();

  serial_bit_feeder #(.WIDTH(W), .LSB_FIRST(LSB_A), .GAP(GAP_A)) dut_a (
    .ck(ck), .reset(reset), .bus(bus_a.slave), .fsm_state(st_a)
  );
  serial_bit_feeder #(.WIDTH(W), .LSB_FIRST(LSB_B), .GAP(GAP_B)) dut_b (
    .ck(ck), .reset(reset), .bus(bus_b.slave), .fsm_state(st_b)
  );

  always #5 ck = ~ck;

  int n_checks = 0;
  int n_err = 0;
  logic [4:0] exp_q_a[$];
  logic [4:0] exp_q_b[$];
  logic [4:0] cur_a, cur_b;
  logic acc_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected per-cycle outputs of one whole frame: data bits, optional parity, gap.
  task automatic push_frame(input int which, input logic [W-1:0] d, input int lsb, input int gap);
    logic [4:0] e[$];
    int flen;
    logic b;
    flen = W;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    flen = W + 1;
`endif
    for (int k = 0; k < W; k++) begin
      b = (lsb != 0) ? d[k] : d[W-1-k];
      e.push_back({1'b0, 1'b1, (k == flen - 1), 1'b1, b});
    end
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    e.push_back({1'b0, 1'b1, 1'b1, 1'b1, ^d});
`endif
    for (int g = 0; g < gap; g++) e.push_back(5'b01000);
    foreach (e[i]) begin
      if (which == 0) exp_q_a.push_back(e[i]);
      else exp_q_b.push_back(e[i]);
    end
  endtask

  // Called at a falling edge: check current outputs, drive inputs, advance model.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d);
    logic acc_b;
    check("out_a", {27'd0, bus_a.din_ready, bus_a.busy, bus_a.done, bus_a.x_valid, bus_a.x}, {27'd0, cur_a});
    check("out_b", {27'd0, bus_b.din_ready, bus_b.busy, bus_b.done, bus_b.x_valid, bus_b.x}, {27'd0, cur_b});
    reset = r;
    bus_a.din = d;  bus_a.din_valid = v;
    bus_b.din = d;  bus_b.din_valid = v;
    if (r) begin
      exp_q_a.delete();
      exp_q_b.delete();
      cur_a = IDLE_V;
      cur_b = IDLE_V;
      acc_a = 1'b0;
    end else begin
      acc_a = v && cur_a[4];
      acc_b = v && cur_b[4];
      if (acc_a) push_frame(0, d, LSB_A, GAP_A);
      if (acc_b) push_frame(1, d, LSB_B, GAP_B);
      cur_a = (exp_q_a.size() > 0) ? exp_q_a.pop_front() : IDLE_V;
      cur_b = (exp_q_b.size() > 0) ? exp_q_b.pop_front() : IDLE_V;
    end
    @(negedge ck);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
  endtask

  task automatic send_held(input logic [W-1:0] d);
    int tries;
    tries = 0;
    do begin
      step(1'b0, 1'b1, d);
      tries++;
    end while (!acc_a && tries < 40);
    check("held_accept", {31'd0, acc_a}, 32'd1);
  endtask

  initial begin
    bus_a.din = '0;  bus_a.din_valid = 1'b0;
    bus_b.din = '0;  bus_b.din_valid = 1'b0;
    cur_a = IDLE_V;
    cur_b = IDLE_V;
    acc_a = 1'b0;
    #2 reset = 1'b1;
    @(negedge ck);
    reset = 1'b0;

    idle(5);

    step(1'b0, 1'b1, 8'b0000_0101);
    idle(14);

    step(1'b0, 1'b1, 8'hA0);
    idle(14);

    send_held(8'hFF);
    send_held(8'h00);
    idle(14);

    // reset lands on the 4th bit of 0xFF
    step(1'b0, 1'b1, 8'hFF);
    idle(3);
    step(1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 8'h35);
    idle(14);

    step(1'b0, 1'b1, 8'b0000_0111);
    idle(14);
    step(1'b0, 1'b1, 8'h03);
    idle(14);

    // reset and din_valid together: reset wins
    step(1'b1, 1'b1, 8'h5A);
    idle(3);

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) != 0), W'($urandom));
    end
    idle(14);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

endmodule
